axis_uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter with an AXI-Stream slave input. It sits between the byte/word stream producer and the `txd` pad. It generalises the fixed 8N1 transmitter with the following additions:
- runtime baud divisor
- 5..DATA_W data bits
- optional parity
- 1 or 2 stop bits
- an inter-packet idle gap inserted after `s_axis_tlast`

---
 rtl/axis_uart_tx_cfg.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axis_uart_tx_cfg.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx_cfg.sv
// axis_uart_tx_cfg: runtime-configurable UART transmitter fed by an AXI-Stream slave port.
// Latency: txd falls on the accept edge; tready returns (1+N+P+S)*DIV clocks later, plus GAP_BITS*DIV after tlast.
// Backpressure: s_axis_tready is high only in IDLE (and not in reset), so exactly one word is held per frame.
//
// Build option: define AXIS_UART_TX_PARITY_EN to include the PARITY state and parity generator;
// when undefined cfg_parity is ignored and no parity bit is ever sent.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast    input word (LSB first on the line), valid, end-of-packet (adds idle gap)
//   s_axis_tready                word accepted on an edge where tvalid && tready
//   cfg_div                      clocks per bit (0/1 select CLK_RATE/BAUD)
//   cfg_data_bits                data bits per frame, clamped to 5..DATA_W
//   cfg_parity                   00/11 none, 01 even, 10 odd
//   cfg_stop2                    0 one stop bit, 1 two stop bits
//   txd                          registered serial line, idle high
//   busy                         high whenever a frame (or its gap) is in progress
//   frame_done                   one-cycle pulse on the last clock of the frame including any gap
module axis_uart_tx_cfg #(
    parameter int CLK_RATE = 100000000,
    parameter int BAUD     = 115200,
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 16,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [3:0]        cfg_data_bits,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(CLK_RATE / BAUD);
    localparam logic [3:0]       DATA_W4  = 4'(DATA_W);
    localparam logic [3:0]       GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

`ifdef AXIS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;       // data bit index in DATA, stop bit index in STOP
    logic [3:0]        gap_q, gap_d;       // bit periods elapsed in GAP
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              txd_q, txd_d;
    logic [DIV_W-1:0]  div_m1_q, div_m1_d; // latched divisor minus one
    logic [3:0]        nbits_m1_q, nbits_m1_d;
    logic              stop2_q, stop2_d;
    logic              last_q, last_d;

    logic [DIV_W-1:0]  eff_div;
    logic [3:0]        nbits_eff;
    logic              accept;
    logic              bit_end;
    logic              frame_done_c;

    assign s_axis_tready = (state_q == IDLE) && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign bit_end       = (baud_q == div_m1_q);

    // 0 and 1 are not usable divisors, so both fall back to the build-time rate.
    assign eff_div   = (cfg_div[DIV_W-1:1] == '0) ? DEF_DIV : cfg_div;
    assign nbits_eff = (cfg_data_bits < 4'd5)    ? 4'd5    :
                       (cfg_data_bits > DATA_W4) ? DATA_W4 : cfg_data_bits;

`ifdef AXIS_UART_TX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic [DATA_W-1:0] data_mask;
    logic              par_calc;

    // Parity covers only the bits actually sent; higher tdata bits are masked off.
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits_eff)) data_mask[i] = 1'b1;
        end
    end
    assign par_calc = ^(s_axis_tdata & data_mask);
`else
    logic unused_parity;
    assign unused_parity = ^cfg_parity;
`endif

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        shreg_d      = shreg_q;
        txd_d        = txd_q;
        div_m1_d     = div_m1_q;
        nbits_m1_d   = nbits_m1_q;
        stop2_d      = stop2_q;
        last_d       = last_q;
`ifdef AXIS_UART_TX_PARITY_EN
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
`endif
        frame_done_c = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    // Everything that shapes the frame is captured here; cfg changes
                    // mid-frame only affect the next word.
                    state_d    = START;
                    txd_d      = 1'b0;
                    baud_d     = '0;
                    bit_d      = '0;
                    gap_d      = '0;
                    shreg_d    = s_axis_tdata;
                    div_m1_d   = eff_div - 1'b1;
                    nbits_m1_d = nbits_eff - 4'd1;
                    stop2_d    = cfg_stop2;
                    last_d     = s_axis_tlast;
`ifdef AXIS_UART_TX_PARITY_EN
                    par_en_d   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                    par_bit_d  = par_calc ^ (cfg_parity == 2'b10);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == nbits_m1_q) begin
                        bit_d = '0;
`ifdef AXIS_UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        // Next bit is shreg_q[1] now; shift so it sits at [0] afterwards.
                        bit_d   = bit_q + 4'd1;
                        shreg_d = shreg_q >> 1;
                        txd_d   = shreg_q[1];
                    end
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (stop2_q && (bit_q == 4'd0)) begin
                        bit_d = 4'd1;
                    end else if (last_q && (GAP_BITS > 0)) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d      = IDLE;
                        frame_done_c = 1'b1;
                    end
                end
            end
            GAP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d      = IDLE;
                        frame_done_c = 1'b1;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            div_m1_q   <= '0;
            nbits_m1_q <= '0;
            stop2_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            div_m1_q   <= div_m1_d;
            nbits_m1_q <= nbits_m1_d;
            stop2_q    <= stop2_d;
            last_q     <= last_d;
`ifdef AXIS_UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_c;

endmodule

// File: tb/tb_axis_uart_tx_cfg.sv
// tb_axis_uart_tx_cfg: directed bench for axis_uart_tx_cfg with a per-cycle waveform model.
// Latency: n/a (testbench).
// Backpressure: drives tvalid and waits (bounded) on the DUT's tready.
module tb_axis_uart_tx_cfg;

    localparam int GAPB = 2;
    localparam int DEFD = 10;   // 1_000_000 / 100_000
`ifdef AXIS_UART_TX_PARITY_EN
    localparam int LEN7 = 40;   // start + 7 data + parity + stop, DIV 4
`else
    localparam int LEN7 = 36;   // start + 7 data + stop, DIV 4
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        txd;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic exp_q[$];          // expected txd for each remaining clock of the current frame
    logic trace [0:255];     // txd per clock of the last frame sent via send()

    axis_uart_tx_cfg #(
        .CLK_RATE(1000000),
        .BAUD    (100000),
        .DATA_W  (8),
        .DIV_W   (16),
        .GAP_BITS(GAPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .cfg_div      (cfg_div),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .txd          (txd),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Builds the whole line waveform of one frame from the current cfg inputs.
    function automatic void push_frame(input logic [7:0] d, input logic l);
        logic bits[$];
        int   dv;
        int   nb;
        logic par;
        dv  = (cfg_div < 16'd2) ? DEFD : int'(cfg_div);
        nb  = (cfg_data_bits < 4'd5) ? 5 : ((cfg_data_bits > 4'd8) ? 8 : int'(cfg_data_bits));
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
`ifdef AXIS_UART_TX_PARITY_EN
        if (cfg_parity == 2'b01) bits.push_back(par);
        if (cfg_parity == 2'b10) bits.push_back(~par);
`endif
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        if (l) begin
            for (int g = 0; g < GAPB; g++) bits.push_back(1'b1);
        end
        foreach (bits[b]) begin
            for (int c = 0; c < dv; c++) exp_q.push_back(bits[b]);
        end
    endfunction

    // Model: an accept happens on an edge where the model is idle and tvalid is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (s_axis_tvalid) begin
            push_frame(s_axis_tdata, s_axis_tlast);
        end
    end

    // Compare DUT outputs against the model every clock, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_rst_txd", txd, 1);
            chk("cmp_rst_busy", busy, 0);
            chk("cmp_rst_tready", s_axis_tready, 0);
            chk("cmp_rst_done", frame_done, 0);
        end else if (exp_q.size() > 0) begin
            chk("cmp_txd", txd, exp_q[0]);
            chk("cmp_busy", busy, 1);
            chk("cmp_tready", s_axis_tready, 0);
            chk("cmp_done", frame_done, (exp_q.size() == 1) ? 1 : 0);
        end else begin
            chk("cmp_idle_txd", txd, 1);
            chk("cmp_idle_busy", busy, 0);
            chk("cmp_idle_tready", s_axis_tready, 1);
            chk("cmp_idle_done", frame_done, 0);
        end
    end

    // Sends one word; len = clocks from accept edge until tready is back, fd_at = clock of frame_done.
    task automatic send(input logic [7:0] d, input logic l, input int chg_at,
                        output int len, output int fd_at, output int waited);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_axis_tready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_axis_tready) chk("accept_timeout", s_axis_tready, 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < 256; k++) trace[k] = 1'b1;
        len   = 0;
        fd_at = -1;
        do begin
            @(negedge clk);
            len++;
            trace[len] = txd;
            if (frame_done && fd_at < 0) fd_at = len;
            if (len == chg_at) cfg_div = 16'd3;
        end while (!s_axis_tready && len < 250);
        if (!s_axis_tready) chk("frame_timeout", s_axis_tready, 1);
        len = len - 1;
    endtask

    // Mid-bit samples of the last traced frame, bit i = i-th bit period.
    function automatic logic [9:0] mid(input int dv);
        logic [9:0] m;
        for (int i = 0; i < 10; i++) m[i] = trace[dv * i + dv / 2];
        return m;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, s_axis_tready, 1);
    endtask

    initial begin
        int len;
        int fd;
        int w;
        int hi;
        int acc [3];
        logic [7:0] words [3];

        rst           = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_div       = 16'd4;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h81;

        // Reset state
        @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tready", s_axis_tready, 0);
        chk("reset_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("release_tready", s_axis_tready, 1);

        // 8N1, DIV 4, 0x55
        send(8'h55, 1'b0, -1, len, fd, w);
        chk("n1_len", len, 40);
        chk("n1_done_at", fd, 40);
        chk("n1_bits", int'(mid(4)), 10'h2AA);

        // 7 data bits, even parity, bit 7 excluded
        cfg_data_bits = 4'd7;
        cfg_parity    = 2'b01;
        send(8'h87, 1'b0, -1, len, fd, w);
        chk("even_len", len, LEN7);
        chk("even_bits", int'(mid(4)), 10'h30E);

        // odd parity, 0x03
        cfg_parity = 2'b10;
        send(8'h03, 1'b0, -1, len, fd, w);
        chk("odd_len", len, LEN7);
        chk("odd_bits", int'(mid(4)), 10'h306);

        // 2 stop bits + tlast gap
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b1;
        send(8'h00, 1'b1, -1, len, fd, w);
        hi = 0;
        for (int k = 1; k <= 52; k++) hi += int'(trace[k]);
        chk("gap_len", len, 52);
        chk("gap_done_at", fd, 52);
        chk("gap_high_clocks", hi, 16);

        // default divisor, cfg_div changed mid-frame
        cfg_stop2 = 1'b0;
        cfg_div   = 16'd0;
        send(8'hA5, 1'b0, 50, len, fd, w);
        chk("def_len", len, 100);
        chk("def_start_end", trace[10], 0);
        chk("def_bit0_begin", trace[11], 1);
        chk("def_bit1_begin", trace[21], 0);
        send(8'h5A, 1'b0, -1, len, fd, w);
        chk("div3_len", len, 30);

        // three queued words, DIV 2
        cfg_div       = 16'd2;
        s_axis_tdata  = words[0];
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = 0;
            @(negedge clk);
            while (!s_axis_tready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (!s_axis_tready) chk("b2b_timeout", s_axis_tready, 1);
            @(posedge clk);
            #1;
            acc[i] = cyc;
            if (i < 2) s_axis_tdata = words[i + 1];
            else s_axis_tvalid = 1'b0;
        end
        chk("b2b_space01", acc[1] - acc[0], 21);
        chk("b2b_space12", acc[2] - acc[1], 21);
        wait_idle("b2b_idle");

        // data-bit clamping
        cfg_data_bits = 4'd2;
        send(8'hFF, 1'b0, -1, len, fd, w);
        chk("clamp_lo_len", len, 14);
        cfg_data_bits = 4'd15;
        send(8'hFF, 1'b0, -1, len, fd, w);
        chk("clamp_hi_len", len, 20);

        // reset in the 3rd data bit
        cfg_div       = 16'd4;
        cfg_data_bits = 4'd8;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_axis_tready && w < 500) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        chk("mid_frame_txd_low", txd, 0);
        rst = 1'b1;
        #1;
        chk("rst_txd_async", txd, 1);
        chk("rst_busy_async", busy, 0);
        chk("rst_tready_async", s_axis_tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h55, 1'b0, -1, len, fd, w);
        chk("post_rst_wait", w, 0);
        chk("post_rst_len", len, 40);
        chk("post_rst_bits", int'(mid(4)), 10'h2AA);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
